// File: rtl/matrix_stream_decoder.sv
// Receive-side decoder for the LED-driver serial stream (sdi/dclk/le/gclk).
// Recovers shifted words, LE-latch commands and per-frame gclk counts for debug readback.
module matrix_stream_decoder #(
    parameter int BOARDS     = 3,
    parameter int WORD_IDX_W = 8,
    parameter int BIT_CNT_W  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sdi_i,
    input  logic                  dclk_i,
    input  logic                  le_i,
    input  logic                  gclk_i,
    output logic                  word_valid_o,
    output logic [15:0]           word_data_o,
    output logic [WORD_IDX_W-1:0] word_index_o,
    output logic                  cmd_valid_o,
    output logic [2:0]            cmd_code_o,
    output logic [4:0]            cmd_latches_o,
    output logic [15:0]           cmd_value_o,
    output logic [BIT_CNT_W-1:0]  cmd_bits_o,
    output logic                  cmd_err_o,
    output logic [15:0]           frame_gclks_o
);

    typedef enum logic [2:0] {
        CMD_DATA    = 3'd0,
        CMD_VSYNC   = 3'd1,
        CMD_CFG1    = 3'd2,
        CMD_CFG2    = 3'd3,
        CMD_ENABLE  = 3'd4,
        CMD_PREACT  = 3'd5,
        CMD_UNKNOWN = 3'd7
    } cmd_code_e;

    localparam logic [BIT_CNT_W-1:0]  DATA_BITS = BIT_CNT_W'(16 * BOARDS);
    localparam logic [BIT_CNT_W-1:0]  BIT_MAX   = '1;
    localparam logic [WORD_IDX_W-1:0] WORD_MAX  = '1;

    logic                  live_q;
    logic                  s_sdi_q, s_dclk_q, s_le_q, s_gclk_q;
    logic                  p_dclk_q, p_le_q, p_gclk_q;
    logic [15:0]           shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_acc;
    logic [4:0]            latch_cnt_q, latch_cnt_d, latch_acc;
    logic [WORD_IDX_W-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]           gclk_cnt_q, gclk_cnt_d;
    logic                  dclk_rise, le_fall, gclk_rise, word_done;
    cmd_code_e             cmd_code_d;

    logic                  word_valid_q;
    logic [15:0]           word_data_q;
    logic [WORD_IDX_W-1:0] word_index_q;
    logic                  cmd_valid_q;
    logic [2:0]            cmd_code_q;
    logic [4:0]            cmd_latches_q;
    logic [15:0]           cmd_value_q;
    logic [BIT_CNT_W-1:0]  cmd_bits_q;
    logic                  cmd_err_q;
    logic [15:0]           frame_gclks_q;

    always_comb begin
        dclk_rise   = s_dclk_q & ~p_dclk_q;
        le_fall     = ~s_le_q & p_le_q;
        gclk_rise   = s_gclk_q & ~p_gclk_q;
        shift_d     = shift_q;
        bit_acc     = bit_cnt_q;
        latch_acc   = latch_cnt_q;
        word_done   = 1'b0;
        if (dclk_rise) begin
            shift_d = {shift_q[14:0], s_sdi_q};
            if (bit_cnt_q != BIT_MAX) begin
                bit_acc   = bit_cnt_q + BIT_CNT_W'(1);
                word_done = (bit_acc[3:0] == 4'd0);
            end
            if (s_le_q && latch_cnt_q != 5'd31) begin
                latch_acc = latch_cnt_q + 5'd1;
            end
        end

        case (latch_acc)
            5'd1:    cmd_code_d = CMD_DATA;
            5'd3:    cmd_code_d = CMD_VSYNC;
            5'd4:    cmd_code_d = CMD_CFG1;
            5'd6:    cmd_code_d = CMD_CFG2;
            5'd12:   cmd_code_d = CMD_ENABLE;
            5'd14:   cmd_code_d = CMD_PREACT;
            default: cmd_code_d = CMD_UNKNOWN;
        endcase

        word_cnt_d = word_cnt_q;
        if (word_done && word_cnt_q != WORD_MAX) begin
            word_cnt_d = word_cnt_q + WORD_IDX_W'(1);
        end
        gclk_cnt_d = gclk_cnt_q;
        if (gclk_rise && gclk_cnt_q != 16'hFFFF) begin
            gclk_cnt_d = gclk_cnt_q + 16'd1;
        end
        bit_cnt_d   = bit_acc;
        latch_cnt_d = latch_acc;

        // A command closes the current transfer; a gclk edge seen right now belongs to the new frame.
        if (le_fall) begin
            bit_cnt_d   = '0;
            latch_cnt_d = '0;
            word_cnt_d  = '0;
            if (cmd_code_d == CMD_VSYNC) begin
                gclk_cnt_d = {15'd0, gclk_rise};
            end
        end
    end

    // Until the first post-reset sample, p_* loads the same raw value as s_* so no edge is seen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live_q        <= 1'b0;
            s_sdi_q       <= 1'b0;
            s_dclk_q      <= 1'b0;
            s_le_q        <= 1'b0;
            s_gclk_q      <= 1'b0;
            p_dclk_q      <= 1'b0;
            p_le_q        <= 1'b0;
            p_gclk_q      <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            latch_cnt_q   <= '0;
            word_cnt_q    <= '0;
            gclk_cnt_q    <= '0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            word_index_q  <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            cmd_latches_q <= '0;
            cmd_value_q   <= '0;
            cmd_bits_q    <= '0;
            cmd_err_q     <= 1'b0;
            frame_gclks_q <= '0;
        end else begin
            live_q      <= 1'b1;
            s_sdi_q     <= sdi_i;
            s_dclk_q    <= dclk_i;
            s_le_q      <= le_i;
            s_gclk_q    <= gclk_i;
            p_dclk_q    <= live_q ? s_dclk_q : dclk_i;
            p_le_q      <= live_q ? s_le_q   : le_i;
            p_gclk_q    <= live_q ? s_gclk_q : gclk_i;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            word_cnt_q  <= word_cnt_d;
            gclk_cnt_q  <= gclk_cnt_d;

            word_valid_q <= word_done;
            if (word_done) begin
                word_data_q  <= shift_d;
                word_index_q <= word_cnt_q;
            end
            cmd_valid_q <= le_fall;
            if (le_fall) begin
                cmd_code_q    <= cmd_code_d;
                cmd_latches_q <= latch_acc;
                cmd_value_q   <= shift_d;
                cmd_bits_q    <= bit_acc;
                cmd_err_q     <= (cmd_code_d == CMD_DATA) && (bit_acc != DATA_BITS);
                if (cmd_code_d == CMD_VSYNC) begin
                    frame_gclks_q <= gclk_cnt_q;
                end
            end
        end
    end

    assign word_valid_o  = word_valid_q;
    assign word_data_o   = word_data_q;
    assign word_index_o  = word_index_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_code_o    = cmd_code_q;
    assign cmd_latches_o = cmd_latches_q;
    assign cmd_value_o   = cmd_value_q;
    assign cmd_bits_o    = cmd_bits_q;
    assign cmd_err_o     = cmd_err_q;
    assign frame_gclks_o = frame_gclks_q;

endmodule

// File: tb/tb_matrix_stream_decoder.sv
// Randomized bench for matrix_stream_decoder: a transaction-level protocol model predicts
// every word/command strobe and a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_matrix_stream_decoder;

    localparam int BOARDS     = 3;
    localparam int WORD_IDX_W = 8;
    localparam int BIT_CNT_W  = 12;

    logic                  clk = 1'b0;
    logic                  rst, sdi, dclk, le, gclk;
    logic                  wordValid;
    logic [15:0]           wordData;
    logic [WORD_IDX_W-1:0] wordIndex;
    logic                  cmdValid;
    logic [2:0]            cmdCode;
    logic [4:0]            cmdLatches;
    logic [15:0]           cmdValue;
    logic [BIT_CNT_W-1:0]  cmdBits;
    logic                  cmdErr;
    logic [15:0]           frameGclks;

    always #5 clk = ~clk;

    matrix_stream_decoder #(
        .BOARDS(BOARDS), .WORD_IDX_W(WORD_IDX_W), .BIT_CNT_W(BIT_CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sdi_i(sdi), .dclk_i(dclk), .le_i(le), .gclk_i(gclk),
        .word_valid_o(wordValid), .word_data_o(wordData), .word_index_o(wordIndex),
        .cmd_valid_o(cmdValid), .cmd_code_o(cmdCode), .cmd_latches_o(cmdLatches),
        .cmd_value_o(cmdValue), .cmd_bits_o(cmdBits), .cmd_err_o(cmdErr),
        .frame_gclks_o(frameGclks)
    );

    typedef struct { int data; int index; } word_t;
    typedef struct { int code; int latches; int value; int bits; int err; bit isVsync; int frame; } cmd_t;

    word_t expWords[$];
    cmd_t  expCmds[$];
    bit    txBits[$];
    int    checkCount = 0;
    int    failCount  = 0;
    int    mShift, mBits, mLatches, mWords, mGclks;
    bit    leNow;
    int    leTable[6] = '{1, 3, 4, 6, 12, 14};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int codeFor(int n);
        case (n)
            1:       return 0;
            3:       return 1;
            4:       return 2;
            6:       return 3;
            12:      return 4;
            14:      return 5;
            default: return 7;
        endcase
    endfunction

    task automatic modelReset();
        mShift = 0; mBits = 0; mLatches = 0; mWords = 0; mGclks = 0;
    endtask

    task automatic modelBit(input bit b, input bit leHigh);
        mShift = ((mShift << 1) | int'(b)) & 'hFFFF;
        if (mBits < 4095) begin
            mBits++;
            if (mBits % 16 == 0) begin
                expWords.push_back('{mShift, (mWords > 255) ? 255 : mWords});
                mWords++;
            end
        end
        if (leHigh && mLatches < 31) mLatches++;
    endtask

    task automatic modelCommand();
        cmd_t c;
        c.code    = codeFor(mLatches);
        c.latches = mLatches;
        c.value   = mShift;
        c.bits    = mBits;
        c.err     = (c.code == 0 && mBits != 16 * BOARDS) ? 1 : 0;
        c.isVsync = (c.code == 1);
        c.frame   = mGclks;
        expCmds.push_back(c);
        if (c.isVsync) mGclks = 0;
        mBits = 0; mLatches = 0; mWords = 0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One dclk pulse carrying bit b; a 1->0 change on le here is a command issued before the bit.
    task automatic applyStimulus(input bit b, input bit l);
        dclk = 1'b0;
        sdi  = b;
        if (leNow && !l) modelCommand();
        le = l;
        leNow = l;
        waitCycles($urandom_range(1, 3));
        dclk = 1'b1;
        modelBit(b, l);
        waitCycles($urandom_range(1, 3));
    endtask

    task automatic endCommand();
        dclk = 1'b0;
        waitCycles($urandom_range(1, 2));
        if (leNow) modelCommand();
        le = 1'b0;
        leNow = 1'b0;
        waitCycles($urandom_range(2, 3));
    endtask

    task automatic sendCommand(input int leCount);
        int n;
        n = txBits.size();
        for (int i = 0; i < n; i++) applyStimulus(txBits[i], i >= n - leCount);
        endCommand();
        txBits.delete();
    endtask

    task automatic pushWord(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) txBits.push_back(w[i]);
    endtask

    task automatic pushRandomBits(input int n);
        for (int i = 0; i < n; i++) txBits.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic pulseGclk(input int n);
        for (int i = 0; i < n; i++) begin
            gclk = 1'b1;
            waitCycles($urandom_range(1, 2));
            gclk = 1'b0;
            waitCycles($urandom_range(1, 2));
            if (mGclks < 65535) mGclks++;
        end
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1;
        waitCycles(n);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic checkResetState();
        checkOutput("rstWordValid", wordValid, 0);
        checkOutput("rstWordData", wordData, 0);
        checkOutput("rstWordIndex", wordIndex, 0);
        checkOutput("rstCmdValid", cmdValid, 0);
        checkOutput("rstCmdCode", cmdCode, 0);
        checkOutput("rstCmdLatches", cmdLatches, 0);
        checkOutput("rstCmdValue", cmdValue, 0);
        checkOutput("rstCmdBits", cmdBits, 0);
        checkOutput("rstCmdErr", cmdErr, 0);
        checkOutput("rstFrameGclks", frameGclks, 0);
    endtask

    always @(negedge clk) begin
        word_t w;
        cmd_t  c;
        if (wordValid) begin
            checkOutput("wordExpected", expWords.size() > 0, 1);
            if (expWords.size() > 0) begin
                w = expWords.pop_front();
                checkOutput("wordData", wordData, w.data);
                checkOutput("wordIndex", wordIndex, w.index);
            end
        end
        if (cmdValid) begin
            checkOutput("cmdExpected", expCmds.size() > 0, 1);
            if (expCmds.size() > 0) begin
                c = expCmds.pop_front();
                checkOutput("cmdCode", cmdCode, c.code);
                checkOutput("cmdLatches", cmdLatches, c.latches);
                checkOutput("cmdValue", cmdValue, c.value);
                checkOutput("cmdBits", cmdBits, c.bits);
                checkOutput("cmdErr", cmdErr, c.err);
                if (c.isVsync) checkOutput("frameGclks", frameGclks, c.frame);
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, choice, nWords, extra;
        bit b;
        rst = 1'b1; sdi = 1'b0; dclk = 1'b0; le = 1'b0; gclk = 1'b0; leNow = 1'b0;
        modelReset();
        applyReset(3);
        checkResetState();

        // Directed transfers from the bring-up list.
        repeat (3) pushWord(16'h0370);
        sendCommand(4);
        repeat (3) pushWord(16'h7FFF);
        sendCommand(6);
        pushWord(16'hA5A5); pushWord(16'h0001); pushWord(16'hFFFF);
        sendCommand(1);
        pushRandomBits(8);
        sendCommand(3);
        pulseGclk(552);
        pushRandomBits(5);
        sendCommand(3);
        checkOutput("frameAfterVsync", frameGclks, 552);
        pushRandomBits(10);
        sendCommand(7);
        pushRandomBits(40);
        sendCommand(1);

        // le falls in the same sample as the 16th dclk edge: bit counts, latch does not.
        for (int i = 0; i < 15; i++) applyStimulus(bit'($urandom_range(0, 1)), i >= 12);
        b = bit'($urandom_range(0, 1));
        dclk = 1'b0; sdi = b;
        waitCycles($urandom_range(1, 2));
        dclk = 1'b1; le = 1'b0;
        modelBit(b, 1'b0);
        modelCommand();
        leNow = 1'b0;
        waitCycles(3);

        // Strobe latency measured from the raw input transition.
        for (int i = 0; i < 15; i++) applyStimulus(bit'($urandom_range(0, 1)), 1'b0);
        b = bit'($urandom_range(0, 1));
        dclk = 1'b0; sdi = b;
        waitCycles(2);
        dclk = 1'b1;
        modelBit(b, 1'b0);
        n = 0;
        do begin waitCycles(1); n++; end while (!wordValid && n < 10);
        checkOutput("wordLatency", n, 2);
        applyStimulus(bit'($urandom_range(0, 1)), 1'b1);
        dclk = 1'b0;
        waitCycles(2);
        modelCommand();
        le = 1'b0; leNow = 1'b0;
        n = 0;
        do begin waitCycles(1); n++; end while (!cmdValid && n < 10);
        checkOutput("cmdLatency", n, 2);
        waitCycles(2);

        for (int r = 0; r < 20; r++) begin
            nWords = $urandom_range(0, 4);
            extra  = $urandom_range(0, 7);
            for (int k = 0; k < nWords; k++) pushWord(16'($urandom));
            pushRandomBits(extra);
            if (txBits.size() == 0) pushRandomBits(1);
            if ($urandom_range(0, 3) == 0) choice = $urandom_range(1, 20);
            else choice = leTable[$urandom_range(0, 5)];
            if (choice > txBits.size()) choice = txBits.size();
            sendCommand(choice);
            pulseGclk($urandom_range(0, 30));
        end

        // Reset mid-word with dclk held high across the release.
        for (int i = 0; i < 9; i++) applyStimulus(bit'($urandom_range(0, 1)), 1'b0);
        waitCycles(3);
        applyReset(1);
        checkResetState();
        pushWord(16'h1234);
        for (int i = 0; i < 16; i++) applyStimulus(txBits[i], 1'b0);
        txBits.delete();
        waitCycles(5);
        pushWord(16'($urandom));
        sendCommand(1);

        waitCycles(10);
        checkOutput("wordsPending", expWords.size(), 0);
        checkOutput("cmdsPending", expCmds.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
